// File: rtl/spi_bitrev_pkg.sv
// spi_bitrev_pkg: shared state encoding and constants for the bit-reversing SPI slave
package spi_bitrev_pkg;
    typedef enum logic [1:0] {IDLE, RX, TX, DONE} state_t;
    localparam logic MISO_IDLE = 1'b1;
    localparam logic MISO_DONE = 1'b0;
    localparam int FRAME_CNT_W = 16;
endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-stage asynchronous-reset synchroniser for a single asynchronous input
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] r;
    always_ff @(posedge clock or posedge reset)
        if (reset) r <= {STAGES{RESET_VAL}};
        else r <= {r[STAGES-2:0], d};
    assign q = r[STAGES-1];
endmodule

// File: rtl/spi_bitrev_slave.sv
// spi_bitrev_slave: oversampled SPI slave that captures a word and returns it LSB-first (bit-reversed)
module spi_bitrev_slave
    import spi_bitrev_pkg::*;
#(
    parameter int   WIDTH       = 8,
    parameter logic CPOL        = 1'b0,
    parameter logic CONTINUOUS  = 1'b0,
    parameter int   SYNC_STAGES = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   sck,
    input  logic                   ss,
    input  logic                   mosi,
    output logic                   miso,
    output logic [WIDTH-1:0]       rx_word,
    output logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_count
);
    localparam int IW = $clog2(WIDTH);
    localparam int CW = IW + 1;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d, shift_n, rx_q, rx_d;
    logic [FRAME_CNT_W-1:0] fcnt_q, fcnt_d;
    logic miso_q, miso_d, done_q, done_d;
    logic sck_s, ss_s, mosi_s, sck_d, rise, fall;
    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck (.clock(clock), .reset(reset), .d(sck ^ CPOL), .q(sck_s));
    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss (.clock(clock), .reset(reset), .d(ss), .q(ss_s));
    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi (.clock(clock), .reset(reset), .d(mosi), .q(mosi_s));
    assign rise = sck_s & ~sck_d;
    assign fall = ~sck_s & sck_d;
    assign shift_n = WIDTH'({shift_q, mosi_s});
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        shift_d = shift_q;
        miso_d = miso_q;
        rx_d = rx_q;
        done_d = 1'b0;
        fcnt_d = fcnt_q;
        // Deselect wins over any edge seen on the same clock
        if (ss_s) begin
            state_d = IDLE;
            cnt_d = '0;
            miso_d = MISO_IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = RX;
                    cnt_d = '0;
                    miso_d = MISO_IDLE;
                end
                RX: begin
                    if (rise) begin
                        shift_d = shift_n;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            rx_d = shift_n;
                            cnt_d = '0;
                            state_d = TX;
                        end
                    end else if (fall) miso_d = MISO_IDLE;
                end
                TX: begin
                    if (fall) miso_d = rx_q[cnt_q[IW-1:0]];
                    else if (rise) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            done_d = 1'b1;
                            fcnt_d = fcnt_q + 1'b1;
                            cnt_d = '0;
                            state_d = CONTINUOUS ? RX : DONE;
                        end
                    end
                end
                DONE: miso_d = fall ? MISO_DONE : miso_q;
                default: begin
                    state_d = IDLE;
                    cnt_d = '0;
                    miso_d = MISO_IDLE;
`ifndef SYNTHESIS
                    $fatal(1, "spi_bitrev_slave: illegal state encoding");
`endif
                end
            endcase
        end
    end
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            shift_q <= '0;
            miso_q <= MISO_IDLE;
            rx_q <= '0;
            done_q <= 1'b0;
            fcnt_q <= '0;
            sck_d <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            shift_q <= shift_d;
            miso_q <= miso_d;
            rx_q <= rx_d;
            done_q <= done_d;
            fcnt_q <= fcnt_d;
            sck_d <= sck_s;
        end
    assign miso = miso_q;
    assign rx_word = rx_q;
    assign frame_done = done_q;
    assign frame_count = fcnt_q;
endmodule

// File: doc/spi_bitrev_slave.md
Name: spi_bitrev_slave

Overview:
- System-clocked SPI slave that captures a WIDTH-bit word from mosi and returns its bit-reversed form on miso during the next WIDTH sck cycles.
- Generalises the fixed 8-bit, sck-clocked bit-reversal peripheral:
  - parametrised word width and clock polarity;
  - oversampled on the SoC clock;
  - optional back-to-back frames while ss stays low;
  - status outputs for the bench and the SoC.
- Sits in perip/ as the loopback target on the SPI master's chip-select line.

Parameters:
- WIDTH, 8: bits per frame (2..32).
- CPOL, 0: idle level of sck. The block uses sck_n = sck ^ CPOL internally. Sampling is always on the leading edge of sck_n, i.e. CPHA = 0.
- CONTINUOUS, 0:
  - 1: after a TX phase, return to RX for the next frame.
  - 0: enter DONE until ss deasserts.
- SYNC_STAGES, 2: synchroniser depth for sck, ss and mosi (at least 2).

Ports:
- clock  in  1  system clock; must be at least 8x the sck frequency.
- reset  in  1  asynchronous, active-high reset.
- sck  in  1  SPI clock from the master (asynchronous).
- ss  in  1  chip select, active-low (asynchronous).
- mosi  in  1  master-out data (asynchronous).
- miso  out  1  slave-out data.
- rx_word  out  WIDTH  last completely received word; held until the next complete RX.
- frame_done  out  1  one-clock pulse when a TX phase completes.
- frame_count  out  16  number of completed frames; wraps at 0xFFFF to 0.

Behaviour:
- Reset (asynchronous):
  - state = IDLE, bit counter = 0, shift register = 0;
  - miso = 1, rx_word = 0, frame_done = 0, frame_count = 0;
  - synchroniser flops set to their idle values: sck_n = 0, ss = 1, mosi = 0.
- Input conditioning:
  - sck, ss and mosi each pass through SYNC_STAGES flops.
  - Edge detect on synchronised sck_n uses one extra flop.
  - rise/fall pulses are one clock wide and occur SYNC_STAGES+1 clocks after the pin edge.
- States: IDLE, RX, TX, DONE.
- Transitions:
  - IDLE -> RX when synchronised ss = 0; counter = 0, miso = 1.
  - RX, on each rise:
    - shift = {shift[WIDTH-2:0], mosi_sync};
    - counter++.
    - On the WIDTH-th rise: rx_word <= the new shift value, counter = 0, -> TX.
    - miso stays 1 throughout RX.
  - TX:
    - On each fall (including the first fall after entering TX): miso <= rx_word[counter].
    - This sends LSB first, so a master reading MSB-first sees bit-reversed data.
    - On each rise: counter++.
    - On the WIDTH-th rise: frame_done pulses for one clock, frame_count++, counter = 0.
    - Next state is DONE if CONTINUOUS = 0, otherwise RX.
  - DONE: miso <= 0 on the next fall, and holds 0 until ss deasserts.
  - Entering RX from TX (CONTINUOUS = 1): miso <= 1 on the next fall.
- ss deassertion (synchronised ss = 1) in any state:
  - -> IDLE on the next clock;
  - counter = 0 and miso = 1 on the same clock;
  - no frame_done pulse, and rx_word is not updated for a partial frame.
  - This takes priority over a simultaneous rise or fall.
- Glitch rule: a rise and a fall can never occur on the same clock, by construction of the edge detector.
- Counter width: $clog2(WIDTH)+1; never exceeds WIDTH.
- frame_count wraps 0xFFFF -> 0x0000 without flagging.
- Illegal state encoding recovers to IDLE with miso = 1. $fatal is used in simulation only, guarded by `ifndef SYNTHESIS.

Decomposition:
- Package spi_bitrev_pkg holds:
  - the state enum (IDLE, RX, TX, DONE, 2-bit);
  - MISO_IDLE = 1'b1 and MISO_DONE = 1'b0;
  - FRAME_CNT_W = 16.
- Sub-module sync_ff (params STAGES, RESET_VAL):
  - generic asynchronous-reset synchroniser;
  - instantiated three times, for sck, ss and mosi.

Test Plan:
- Basic frame, WIDTH=8, CPOL=0, CONTINUOUS=0, sck = clock/8: ss low, send 0x1F MSB-first.
  - Master then reads 0xF8 during 8 more sck cycles.
  - rx_word = 0x1F, frame_done pulses once, frame_count = 1.
  - miso = 0 afterwards until ss goes high, then miso = 1.
- CONTINUOUS=1: frames 0x01 then 0xC4 with ss held low.
  - Reads are 0x80 then 0x23.
  - frame_count = 2, two frame_done pulses, miso = 1 during each RX phase.
- Abort: ss rises after 5 RX bits.
  - miso = 1, state IDLE, rx_word unchanged, no frame_done.
  - A new frame of 0x3C then returns 0x3C correctly (palindrome check of counter reset).
- CPOL=1, WIDTH=16: send 0x8001 -> read 0x8001. Send 0x1234 -> read 0x2C48. rx_word = 0x1234.
- Asynchronous reset asserted mid-TX:
  - all outputs return to reset values within the same cycle: miso = 1, frame_count = 0, rx_word = 0;
  - the next frame 0x0F reads back 0xF0.
- Wrap: preload by running 65536 short frames (WIDTH=2) -> frame_count = 0x0000 after the last frame_done.
